// File: rtl/player_key_ctrl.sv
// Player keyboard front-end: per-frame debounce of up/down/kick keys and the kick FSM.
// Define PLAYER_KICK_COOLDOWN_EN to add a COOLDOWN_FRAMES lockout after each kick.
module player_key_ctrl #(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned KICK_WINDOW     = 8,
    parameter int unsigned KICK_HOLD       = 15,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_kick,
    output logic       Y_up,
    output logic       Y_down,
    output logic       pressed,
    output logic       second,
    output logic [1:0] kick_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    localparam int unsigned KMAX = (KICK_WINDOW > KICK_HOLD) ? KICK_WINDOW : KICK_HOLD;
    localparam int unsigned KW   = ($clog2(KMAX + 1) < 1) ? 1 : $clog2(KMAX + 1);
    localparam logic [KW-1:0] C_KMAX = KW'(KMAX);
    localparam logic [KW-1:0] C_WIN  = KW'(KICK_WINDOW);
    localparam logic [KW-1:0] C_HOLD = KW'(KICK_HOLD);
    localparam logic [4:0]    C_DB   = 5'(DEBOUNCE_FRAMES);
    localparam bit HOLD_IN_WINDOW    = (KICK_HOLD <= KICK_WINDOW);

    logic [2:0]    w_raw;
    logic [2:0]    r_deb;
    logic [2:0]    w_deb_nxt;
    logic [3:0]    r_dcnt     [3];
    logic [3:0]    w_dcnt_nxt [3];
    logic [1:0]    r_state;
    logic [KW-1:0] r_kcnt;
    logic [KW-1:0] w_k_inc;
    logic          w_kick_rise;
    logic          w_cool_done;
    logic          r_y_up;
    logic          r_y_down;
    logic          r_pressed;
    logic          r_second;

    assign w_raw = {key_kick, key_down, key_up};

    // A sample equal to the accepted level clears the run; otherwise the run grows until accepted.
    always_comb begin
        w_deb_nxt = r_deb;
        for (int unsigned k = 0; k < 3; k++) begin
            w_dcnt_nxt[k] = r_dcnt[k];
            if (startOfFrame) begin
                if (w_raw[k] == r_deb[k]) begin
                    w_dcnt_nxt[k] = '0;
                end else if ({1'b0, r_dcnt[k]} + 5'd1 >= C_DB) begin
                    w_deb_nxt[k]  = w_raw[k];
                    w_dcnt_nxt[k] = '0;
                end else begin
                    w_dcnt_nxt[k] = r_dcnt[k] + 4'd1;
                end
            end
        end
    end

    assign w_kick_rise = w_deb_nxt[2] & ~r_deb[2];
    assign w_k_inc     = (r_kcnt == C_KMAX) ? r_kcnt : r_kcnt + KW'(1);

`ifdef PLAYER_KICK_COOLDOWN_EN
    localparam int unsigned CW = ($clog2(COOLDOWN_FRAMES + 1) < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] C_COOL = CW'(COOLDOWN_FRAMES);

    logic [CW-1:0] r_ccnt;
    logic [CW-1:0] w_c_inc;

    assign w_c_inc     = (r_ccnt == C_COOL) ? r_ccnt : r_ccnt + CW'(1);
    assign w_cool_done = (w_c_inc >= C_COOL);

    always_ff @(posedge clk) begin
        if (reset || r_state != S_LOCK) begin
            r_ccnt <= '0;
        end else if (startOfFrame) begin
            r_ccnt <= w_c_inc;
        end
    end
`else
    assign w_cool_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb     <= '0;
            for (int unsigned k = 0; k < 3; k++) r_dcnt[k] <= '0;
            r_y_up    <= 1'b0;
            r_y_down  <= 1'b0;
            r_state   <= S_IDLE;
            r_kcnt    <= '0;
            r_pressed <= 1'b0;
            r_second  <= 1'b0;
        end else begin
            r_deb    <= w_deb_nxt;
            for (int unsigned k = 0; k < 3; k++) r_dcnt[k] <= w_dcnt_nxt[k];
            r_y_up   <= w_deb_nxt[0] & ~w_deb_nxt[1];
            r_y_down <= w_deb_nxt[1] & ~w_deb_nxt[0];
            r_second <= 1'b0;
            if (startOfFrame) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_kick_rise) begin
                            r_state   <= S_ARMED;
                            r_pressed <= 1'b1;
                            r_kcnt    <= '0;
                        end
                    end
                    S_ARMED: begin
                        r_kcnt <= w_k_inc;
                        if (w_k_inc >= C_WIN) begin
                            r_pressed <= 1'b0;
                            // A hold shorter than the window releases at the window's end.
                            if (HOLD_IN_WINDOW) begin
                                r_second <= 1'b1;
                                r_state  <= S_LOCK;
                            end else begin
                                r_state  <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        r_kcnt <= w_k_inc;
                        if (w_k_inc >= C_HOLD) begin
                            r_second <= 1'b1;
                            r_state  <= S_LOCK;
                        end
                    end
                    S_LOCK: begin
                        if (w_cool_done && !w_deb_nxt[2]) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign Y_up       = r_y_up;
    assign Y_down     = r_y_down;
    assign pressed    = r_pressed;
    assign second     = r_second;
    assign kick_state = r_state;

endmodule

// File: tb/tb_player_key_ctrl.sv
// Directed bench for player_key_ctrl: vector table for debounce/move, scripted kick sequences.
// Expected LOCK exit follows PLAYER_KICK_COOLDOWN_EN when the bench is built with it.
module tb_player_key_ctrl;

    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       key_up;
    logic       key_down;
    logic       key_kick;
    logic       Y_up;
    logic       Y_down;
    logic       pressed;
    logic       second;
    logic [1:0] kick_state;

    typedef struct {
        logic       rst;
        logic       sof;
        logic       up;
        logic       dn;
        logic       kk;
        logic [5:0] exp;   // {Y_up, Y_down, pressed, second, kick_state}
    } vec_t;

    vec_t tbl [40];
    int   nt;
    int   n_vec;
    int   n_err;

    player_key_ctrl #(
        .DEBOUNCE_FRAMES(2),
        .KICK_WINDOW    (8),
        .KICK_HOLD      (15),
        .COOLDOWN_FRAMES(30)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .startOfFrame(startOfFrame),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_kick    (key_kick),
        .Y_up        (Y_up),
        .Y_down      (Y_down),
        .pressed     (pressed),
        .second      (second),
        .kick_state  (kick_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic u, input logic d,
                       input logic k, input logic [5:0] e);
        tbl[nt] = '{r, s, u, d, k, e};
        nt++;
    endtask

    task automatic step(input logic r, input logic s, input logic u, input logic d,
                        input logic k, input logic [5:0] e, input string name);
        logic [5:0] act;
        reset        = r;
        startOfFrame = s;
        key_up       = u;
        key_down     = d;
        key_kick     = k;
        @(posedge clk);
        #1;
        act = {Y_up, Y_down, pressed, second, kick_state};
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: {Y_up,Y_down,pressed,second,kick_state} got %b want %b", name, act, e);
        end
    endtask

    // State after the frame n frames past ARMED entry, kick released so debounce falls at n == hold.
    function automatic logic [1:0] exp_state(input int n, input int hold);
        int n_exit;
`ifdef PLAYER_KICK_COOLDOWN_EN
        n_exit = (hold > 45) ? hold : 45;
`else
        n_exit = (hold > 16) ? hold : 16;
`endif
        if (n < 0)       return 2'd0;
        if (n < 8)       return 2'd1;
        if (n < 15)      return 2'd2;
        if (n < n_exit)  return 2'd3;
        return 2'd0;
    endfunction

    task automatic kick_run(input int hold, input int total, input string name);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, {name, "_rst"});
        for (int f = 1; f <= total; f++) begin
            int         n;
            logic       kk;
            logic [1:0] st;
            n  = f - 2;
            kk = (f <= hold);
            st = exp_state(n, hold);
            step(1'b0, 1'b1, 1'b0, 1'b0, kk, {2'b00, st == 2'd1, n == 15, st},
                 $sformatf("%s_f%0d", name, f));
            step(1'b0, 1'b0, 1'b0, 1'b0, kk, {2'b00, st == 2'd1, 1'b0, st},
                 $sformatf("%s_f%0d_gap", name, f));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nt    = 0;
        reset = 1'b1; startOfFrame = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_kick = 1'b0;

        //   rst   sof   up    dn    kick  expected
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b10_0_0_00);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b10_0_0_00);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b10_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b10_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b10_0_0_00);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b01_0_0_00);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b01_0_0_00);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b01_0_0_00);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00);

        for (int i = 0; i < nt; i++) begin
            step(tbl[i].rst, tbl[i].sof, tbl[i].up, tbl[i].dn, tbl[i].kk, tbl[i].exp,
                 $sformatf("vec%0d", i));
        end

        kick_run(3, 50, "kick3");
        kick_run(60, 66, "kick60");

        kick_run(3, 12, "abort");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00, "abort_rst");
        for (int f = 0; f < 20; f++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00, $sformatf("abort_f%0d", f));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b00_0_0_00, $sformatf("abort_f%0d_gap", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
